bus_master_arbiter: RTL and testbench
=====================================

Name: bus_master_arbiter

Overview:
- Shares the single serial-bus master port (m_instruction / m_data_out / m_tx_done) between NUM_REQ local requesters, e.g. the data-alter/increment block and a switch/loopback source.
- Round-robin arbitration. The winner's instruction and data are latched and held on the master port until m_tx_done.
- Completion is pulsed back to the winner, then a programmable idle gap is inserted before the next grant.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- DATA_W, 8, data width per requester
- GAP_CYCLES, 2, idle cycles after each completed transaction (0 allowed)
- TIMEOUT_CYCLES, 1000, watchdog limit in cycles (used only with BUS_ARB_TIMEOUT_EN)

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester request; held high until req_done
- req_instr  input  2*NUM_REQ  per-requester instruction, requester i at bits [2i+1:2i]; 2'b00 = NOP
- req_data  input  DATA_W*NUM_REQ  per-requester data, requester i at bits [DATA_W*i +: DATA_W]
- req_grant  output  NUM_REQ  one-hot; high for the whole owned transaction
- req_done  output  NUM_REQ  one-cycle completion pulse to the owner
- req_error  output  NUM_REQ  one-cycle timeout pulse (0 unless BUS_ARB_TIMEOUT_EN)
- m_instruction  output  2  to master port; 2'b00 when idle
- m_data_out  output  DATA_W  to master port
- m_tx_done  input  1  master port transaction complete
- busy  output  1  high in BUSY and GAP

Behaviour:
- Reset (async, immediate): state=IDLE; req_grant=0, req_done=0, req_error=0, m_instruction=2'b00, m_data_out=0, busy=0; rr pointer=0; gap and timeout counters=0. Any in-flight transaction is abandoned; no done is issued.
- Eligibility: requester i is eligible when req_valid[i]=1 and its req_instr != 2'b00. A NOP with valid is ignored and never granted.
- IDLE:
  - If any requester is eligible, pick the first eligible index scanning from rr pointer upward, wrapping modulo NUM_REQ.
  - On the next edge: req_grant[w]=1, m_instruction=req_instr[w], m_data_out=req_data[w] (registered, latched once), state=BUSY.
  - Latency from request to port drive is 1 cycle.
- BUSY:
  - m_instruction and m_data_out hold the latched values. Requester changes to instr, data or valid are ignored until completion.
  - m_tx_done is sampled only in BUSY; it is ignored in IDLE and GAP, including the grant cycle itself.
  - On m_tx_done=1 at the next edge: m_instruction=2'b00, req_grant=0, req_done[w]=1 for one cycle, rr pointer=(w+1) mod NUM_REQ.
  - Then go to GAP if GAP_CYCLES>0, else IDLE.
- GAP:
  - Count GAP_CYCLES clocks with port idle, then return to IDLE.
  - Requests pending during GAP wait; none are lost.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0.
- The requester that just finished may be re-granted only if no other requester is eligible.
- req_done and the new-grant decision never coincide. The earliest re-grant of the same requester comes one cycle after the IDLE entry that follows done.
- Counters are sized with $clog2(max+1). The rr pointer wraps at NUM_REQ.

Optional Feature:
- Macro: BUS_ARB_TIMEOUT_EN.
- Enabled:
  - The timeout counter runs in BUSY and clears on each grant.
  - When it reaches TIMEOUT_CYCLES without m_tx_done: m_instruction=2'b00, req_grant=0, req_error[w]=1 for one cycle, no req_done, rr pointer advances, state goes to GAP/IDLE as on normal completion.
  - If m_tx_done arrives in the same cycle the limit is reached, normal completion wins.
- Disabled: no counter logic is built; req_error is tied to 0; BUSY waits indefinitely.

Test Plan:
- Single requester: req_valid[0]=1, instr=2'b10, data=8'h5A; m_tx_done pulsed 4 cycles after grant -> m_instruction=2'b10 and m_data_out=8'h5A from cycle 1 until the done edge, then req_done[0] pulses once, then 2 idle cycles.
- Contention: both requesters valid continuously (data 8'h11 and 8'h22), 3 transactions each -> grant order 0,1,0,1,0,1; m_data_out alternates 11,22.
- Data stability: requester changes data 8'h33->8'h44 mid-BUSY -> m_data_out stays 8'h33 until done.
- NOP and spurious done: valid=1 with instr=00 -> no grant. m_tx_done pulsed while IDLE -> no req_done, state unchanged.
- Reset mid-BUSY: assert reset 2 cycles after grant -> all outputs 0 immediately and no req_done. After release, a pending request is granted starting from requester 0.
- With BUS_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=10, m_tx_done never asserted -> req_error[w] pulses 10 cycles after grant, port returns to 00, and the next requester is granted after the gap.

Source files
------------

// File: rtl/bus_master_arbiter.sv
// bus_master_arbiter: round-robin owner of the shared serial-bus master port.
// Optional BUSY watchdog is built when BUS_ARB_TIMEOUT_EN is defined.
module bus_master_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int DATA_W         = 8,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [2*NUM_REQ-1:0]       req_instr,
  input  logic [DATA_W*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_grant,
  output logic [NUM_REQ-1:0]         req_done,
  output logic [NUM_REQ-1:0]         req_error,
  output logic [1:0]                 m_instruction,
  output logic [DATA_W-1:0]          m_data_out,
  input  logic                       m_tx_done,
  output logic                       busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       rr_q, rr_d;
  logic [IW-1:0]       own_q, own_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic [NUM_REQ-1:0]  err_q, err_d;
  logic [1:0]          instr_q, instr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [NUM_REQ-1:0]  elig;
  logic                found;
  logic [IW-1:0]       win;
  logic                expire;
  int                  idx;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++)
      elig[i] = req_valid[i] && (req_instr[2*i +: 2] != 2'b00);
  end

  // first eligible index at or above the rr pointer, wrapping
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_REQ)
        idx = idx - NUM_REQ;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_q, to_d;

  always_comb begin
    to_d   = '0;
    expire = 1'b0;
    if (state_q == BUSY) begin
      to_d   = to_q + 1'b1;
      expire = !m_tx_done && (int'(to_q) == TIMEOUT_CYCLES - 1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      to_q <= '0;
    else
      to_q <= to_d;
  end
`else
  logic unused_to;
  assign unused_to = ^TIMEOUT_CYCLES;
  assign expire    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    own_d   = own_q;
    gap_d   = gap_q;
    grant_d = grant_q;
    instr_d = instr_q;
    data_d  = data_q;
    done_d  = '0;
    err_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          own_d   = win;
          grant_d = NUM_REQ'(1) << win;
          instr_d = req_instr[2*win +: 2];
          data_d  = req_data[DATA_W*win +: DATA_W];
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (m_tx_done || expire) begin
          grant_d = '0;
          instr_d = 2'b00;
          data_d  = '0;
          if (m_tx_done)
            done_d[own_q] = 1'b1;
          else
            err_d[own_q] = 1'b1;
          rr_d    = (int'(own_q) == NUM_REQ - 1) ? '0 : own_q + 1'b1;
          gap_d   = '0;
          state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (int'(gap_q) == GAP_CYCLES - 1)
          state_d = IDLE;
        else
          gap_d = gap_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= '0;
      own_q   <= '0;
      gap_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
      instr_q <= 2'b00;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      own_q   <= own_d;
      gap_q   <= gap_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      instr_q <= instr_d;
      data_q  <= data_d;
    end
  end

  assign req_grant     = grant_q;
  assign req_done      = done_q;
  assign req_error     = err_q;
  assign m_instruction = instr_q;
  assign m_data_out    = data_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_bus_master_arbiter.sv
// tb_bus_master_arbiter: vector table, directed corner cases and a
// randomized run against a transaction-level reference model.
module tb_bus_master_arbiter;

  localparam int N   = 2;
  localparam int DW  = 8;
  localparam int GAP = 2;
  localparam int TO  = 10;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [2*N-1:0]  req_instr;
  logic [DW*N-1:0] req_data;
  logic            m_tx_done;
  logic [N-1:0]    req_grant, req_done, req_error;
  logic [1:0]      m_instruction;
  logic [DW-1:0]   m_data_out;
  logic            busy;

  bus_master_arbiter #(
    .NUM_REQ(N), .DATA_W(DW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_instr(req_instr), .req_data(req_data),
    .req_grant(req_grant), .req_done(req_done), .req_error(req_error),
    .m_instruction(m_instruction), .m_data_out(m_data_out),
    .m_tx_done(m_tx_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [N-1:0]    v;
    logic [2*N-1:0]  ins;
    logic [DW*N-1:0] d;
    logic            td;
    logic [N-1:0]    g;
    logic [1:0]      mi;
    logic [DW-1:0]   md;
    logic [N-1:0]    dn;
    logic            bz;
  } vec_t;

  vec_t tbl[15];

  // transaction-level reference: who owns the port, and for how long
  int            m_own, m_rr, m_gap, m_age;
  logic [1:0]    m_i;
  logic [DW-1:0] m_d;
  logic [N-1:0]  e_done, e_err;

  task automatic model_reset();
    m_own = -1; m_rr = 0; m_gap = 0; m_age = 0;
    m_i = 2'b00; m_d = '0; e_done = '0; e_err = '0;
  endtask

  task automatic model_step();
    e_done = '0;
    e_err  = '0;
    if (m_own >= 0) begin
      m_age++;
      if (m_tx_done)
        e_done[m_own] = 1'b1;
      else if (TO_EN && m_age >= TO)
        e_err[m_own] = 1'b1;
      if ((e_done | e_err) != '0) begin
        m_rr  = (m_own + 1) % N;
        m_own = -1;
        m_gap = GAP;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_rr + k) % N;
        if (req_valid[i] && req_instr[2*i +: 2] != 2'b00) begin
          m_own = i;
          m_i   = req_instr[2*i +: 2];
          m_d   = req_data[DW*i +: DW];
          m_age = 0;
          break;
        end
      end
    end
  endtask

  task automatic model_check(input int c);
    logic [N-1:0] eg;
    eg = (m_own >= 0) ? N'(1 << m_own) : '0;
    chk($sformatf("rnd%0d_grant", c), req_grant, eg);
    chk($sformatf("rnd%0d_instr", c), m_instruction,
        (m_own >= 0) ? m_i : 2'b00);
    chk($sformatf("rnd%0d_data", c), m_data_out,
        (m_own >= 0) ? m_d : '0);
    chk($sformatf("rnd%0d_done", c), req_done, e_done);
    chk($sformatf("rnd%0d_err", c), req_error, e_err);
    chk($sformatf("rnd%0d_busy", c), busy,
        (m_own >= 0) || (m_gap > 0));
  endtask

  task automatic set_in(input logic [N-1:0] v, input logic [2*N-1:0] ins,
                        input logic [DW*N-1:0] d, input logic td);
    req_valid = v; req_instr = ins; req_data = d; m_tx_done = td;
  endtask

  initial begin
    int n;
    // single requester, idle gap, NOP, spurious done, contention, stability
    tbl[0]  = '{2'b01, 4'b0010, 16'h005A, 0, 2'b01, 2'd2, 8'h5A, 2'b00, 1};
    tbl[1]  = '{2'b01, 4'b0010, 16'h005A, 0, 2'b01, 2'd2, 8'h5A, 2'b00, 1};
    tbl[2]  = '{2'b01, 4'b0001, 16'h00FF, 0, 2'b01, 2'd2, 8'h5A, 2'b00, 1};
    tbl[3]  = '{2'b01, 4'b0010, 16'h005A, 0, 2'b01, 2'd2, 8'h5A, 2'b00, 1};
    tbl[4]  = '{2'b01, 4'b0010, 16'h005A, 1, 2'b00, 2'd0, 8'h00, 2'b01, 1};
    tbl[5]  = '{2'b00, 4'b0000, 16'h0000, 0, 2'b00, 2'd0, 8'h00, 2'b00, 1};
    tbl[6]  = '{2'b00, 4'b0000, 16'h0000, 0, 2'b00, 2'd0, 8'h00, 2'b00, 0};
    tbl[7]  = '{2'b01, 4'b0000, 16'h0099, 1, 2'b00, 2'd0, 8'h00, 2'b00, 0};
    tbl[8]  = '{2'b11, 4'b0101, 16'h2211, 0, 2'b10, 2'd1, 8'h22, 2'b00, 1};
    tbl[9]  = '{2'b11, 4'b0101, 16'h2211, 1, 2'b00, 2'd0, 8'h00, 2'b10, 1};
    tbl[10] = '{2'b11, 4'b0101, 16'h2211, 0, 2'b00, 2'd0, 8'h00, 2'b00, 1};
    tbl[11] = '{2'b11, 4'b0101, 16'h2233, 0, 2'b00, 2'd0, 8'h00, 2'b00, 0};
    tbl[12] = '{2'b11, 4'b0101, 16'h2233, 1, 2'b01, 2'd1, 8'h33, 2'b00, 1};
    tbl[13] = '{2'b11, 4'b0101, 16'h2244, 0, 2'b01, 2'd1, 8'h33, 2'b00, 1};
    tbl[14] = '{2'b11, 4'b0101, 16'h2244, 1, 2'b00, 2'd0, 8'h00, 2'b01, 1};

    reset = 1'b1;
    set_in('0, '0, '0, 1'b0);
    #12;
    chk("rst_grant", req_grant, 0);
    chk("rst_instr", m_instruction, 0);
    chk("rst_data", m_data_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", req_done, 0);
    reset = 1'b0;

    for (int r = 0; r < 15; r++) begin
      set_in(tbl[r].v, tbl[r].ins, tbl[r].d, tbl[r].td);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_grant", r), req_grant, tbl[r].g);
      chk($sformatf("vec%0d_instr", r), m_instruction, tbl[r].mi);
      chk($sformatf("vec%0d_data", r), m_data_out, tbl[r].md);
      chk($sformatf("vec%0d_done", r), req_done, tbl[r].dn);
      chk($sformatf("vec%0d_busy", r), busy, tbl[r].bz);
      chk($sformatf("vec%0d_err", r), req_error, 0);
    end

    // reset mid-BUSY: rr is 1 here, so a cleared pointer must pick req 0
    set_in(2'b10, 4'b1100, 16'h7700, 1'b0);
    n = 0;
    while (req_grant == '0 && n < 10) begin
      @(posedge clk); #1; n++;
    end
    chk("rb_grant", req_grant, 2'b10);
    chk("rb_data", m_data_out, 8'h77);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("rb_async_grant", req_grant, 0);
    chk("rb_async_instr", m_instruction, 0);
    chk("rb_async_data", m_data_out, 0);
    chk("rb_async_busy", busy, 0);
    m_tx_done = 1'b1;
    @(posedge clk); #1;
    chk("rb_no_done", req_done, 0);
    set_in(2'b11, 4'b1101, 16'h7766, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rb_regrant", req_grant, 2'b01);
    chk("rb_regrant_data", m_data_out, 8'h66);
    m_tx_done = 1'b1;
    @(posedge clk); #1;
    chk("rb_done", req_done, 2'b01);
    m_tx_done = 1'b0;

`ifdef BUS_ARB_TIMEOUT_EN
    reset = 1'b1;
    set_in(2'b11, 4'b0110, 16'hBBAA, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("to_grant", req_grant, 2'b01);
    n = 0;
    while (req_error == '0 && n < 30) begin
      @(posedge clk); #1; n++;
    end
    chk("to_latency", n, TO);
    chk("to_error", req_error, 2'b01);
    chk("to_grant_clr", req_grant, 0);
    chk("to_instr_clr", m_instruction, 0);
    chk("to_no_done", req_done, 0);
    n = 0;
    while (req_grant == '0 && n < 10) begin
      @(posedge clk); #1; n++;
    end
    chk("to_next_lat", n, GAP + 1);
    chk("to_next_grant", req_grant, 2'b10);
`endif

    // randomized run against the reference model
    reset = 1'b1;
    set_in('0, '0, '0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      set_in(N'($urandom), (2*N)'($urandom), (DW*N)'($urandom),
             $urandom_range(0, 3) == 0);
      @(posedge clk);
      model_step();
      #1;
      model_check(c);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
